// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Clears the byte-offset bits so redirects always land on an instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// Used both as the in-flight PC queue and as the fetched-instruction buffer.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic [31:0],
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    rd_en = pop && !empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    wr_en = push && (!full || pop);
    head  = mem[rptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-memory fetch front end with redirect handling.
// NextAddr comes from the external AdderPC stage.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NextAddr,
  output logic [31:0] Addr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        err_unexpected_rsp
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [CW-1:0] discard;
  logic          err;

  // The in-flight queue occupancy is the outstanding-request count.
  logic [CW-1:0] outstanding;
  logic          pcq_empty;
  logic [31:0]   pcq_head;
  logic [CW-1:0] ibuf_count;
  logic          ibuf_empty;
  fetch_entry_t  ibuf_head;
  fetch_entry_t  ibuf_push_data;

  logic          req_valid;
  logic          hs;
  logic          rsp_ok;
  logic          rsp_unexp;
  logic          rsp_keep;
  logic          ibuf_pop;
  logic [CW:0]   credit_used;
  logic [CW-1:0] out_next;

  always_comb begin
    credit_used    = {1'b0, outstanding} + {1'b0, ibuf_count};
    req_valid      = (state == ST_RUN) && (credit_used < (CW+1)'(FIFO_DEPTH));
    hs             = req_valid && imem_req_ready;
    rsp_ok         = imem_rsp_valid && !pcq_empty;
    rsp_unexp      = imem_rsp_valid && pcq_empty;
    rsp_keep       = rsp_ok && (discard == '0) && !redirect_valid;
    ibuf_pop       = !ibuf_empty && if_ready && !redirect_valid;
    out_next       = outstanding + CW'(hs) - CW'(rsp_ok);
    ibuf_push_data = '{pc: pcq_head, instr: imem_rsp_data};
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (logic [31:0])
  ) u_pcq (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (hs),
    .push_data (pc),
    .pop       (rsp_ok),
    .head      (pcq_head),
    .count     (outstanding),
    .empty     (pcq_empty)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (ibuf_push_data),
    .pop       (ibuf_pop),
    .head      (ibuf_head),
    .count     (ibuf_count),
    .empty     (ibuf_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_BOOT;
      pc      <= RESET_PC;
      discard <= '0;
      err     <= 1'b0;
    end else begin
      if (rsp_unexp) begin
        err <= 1'b1;
      end
      // Requests still in flight, including one accepted this cycle, belong to the old path.
      if (redirect_valid) begin
        pc      <= align_pc(redirect_target);
        discard <= out_next;
        state   <= (out_next != '0) ? ST_DRAIN : ST_RUN;
      end else begin
        case (state)
          ST_BOOT: state <= ST_RUN;
          ST_RUN: begin
            if (hs) begin
              pc <= NextAddr;
            end
          end
          ST_DRAIN: begin
            if (rsp_ok) begin
              discard <= discard - CW'(1);
              if (discard == CW'(1)) begin
                state <= ST_RUN;
              end
            end
          end
          default: state <= ST_BOOT;
        endcase
      end
    end
  end

  always_comb begin
    Addr               = pc;
    imem_req_addr      = pc;
    imem_req_valid     = req_valid;
    if_valid           = !ibuf_empty;
    if_instr           = ibuf_head.instr;
    if_pc              = ibuf_head.pc;
    err_unexpected_rsp = err;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a 1-cycle-latency in-order memory model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] NextAddr;
  logic [31:0] Addr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        err_unexpected_rsp;

  always #5 clk = ~clk;

  // AdderPC stand-in.
  assign NextAddr = Addr + 32'd4;

  pc_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .NextAddr           (NextAddr),
    .Addr               (Addr),
    .redirect_valid     (redirect_valid),
    .redirect_target    (redirect_target),
    .imem_req_valid     (imem_req_valid),
    .imem_req_ready     (imem_req_ready),
    .imem_req_addr      (imem_req_addr),
    .imem_rsp_valid     (imem_rsp_valid),
    .imem_rsp_data      (imem_rsp_data),
    .if_valid           (if_valid),
    .if_ready           (if_ready),
    .if_instr           (if_instr),
    .if_pc              (if_pc),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  int unsigned total  = 0;
  int unsigned passed = 0;
  bit          rsp_en;
  logic [31:0] pend[$];
  logic [31:0] reqlog[$];
  logic [31:0] gotpc[$];
  logic [31:0] gotins[$];

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] ifpc;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One clock cycle: log handshakes, advance, then present the next memory response.
  task automatic cyc();
    bit hs;
    bit pp;
    hs = imem_req_valid && imem_req_ready;
    pp = if_valid && if_ready && !redirect_valid;
    if (hs) begin
      pend.push_back(imem_req_addr);
      reqlog.push_back(imem_req_addr);
    end
    if (pp) begin
      gotpc.push_back(if_pc);
      gotins.push_back(if_instr);
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (rsp_en && pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = '0;
    if_ready        = 1'b1;
    rsp_en          = 1'b1;
    pend.delete();
    reqlog.delete();
    gotpc.delete();
    gotins.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_pops(input int unsigned n, input int unsigned budget);
    for (int unsigned i = 0; i < budget && gotpc.size() < n; i++) cyc();
    if (gotpc.size() < n) begin
      total++;
      $display("FAIL pop_timeout: got %0d pops expected %0d", gotpc.size(), n);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    tbl[5] = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};

    // Reset state and steady fetch timeline.
    do_reset();
    #1;
    chk("rst_err", {31'b0, err_unexpected_rsp}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    for (int i = 0; i < 7; i++) begin
      if_ready = tbl[i].rdy;
      #1;
      chk($sformatf("req_valid[%0d]", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].rv});
      chk($sformatf("addr[%0d]", i), Addr, tbl[i].addr);
      chk($sformatf("req_addr[%0d]", i), imem_req_addr, tbl[i].addr);
      chk($sformatf("if_valid[%0d]", i), {31'b0, if_valid}, {31'b0, tbl[i].ifv});
      if (tbl[i].ifv) begin
        chk($sformatf("if_pc[%0d]", i), if_pc, tbl[i].ifpc);
        chk($sformatf("if_instr[%0d]", i), if_instr, mdata(tbl[i].ifpc));
      end
      cyc();
    end

    // Decode stall: credit limit caps requests at FIFO_DEPTH.
    do_reset();
    if_ready = 1'b0;
    repeat (8) cyc();
    #1;
    chk("stall_reqs", reqlog.size(), 32'd2);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    if_ready = 1'b1;
    for (int i = 0; i < 10 && reqlog.size() < 3; i++) cyc();
    chk("resume_reqs", reqlog.size(), 32'd3);
    if (reqlog.size() >= 3) chk("resume_addr", reqlog[2], 32'h8);
    wait_pops(3, 20);
    if (gotpc.size() >= 3) begin
      chk("stall_pc0", gotpc[0], 32'h0);
      chk("stall_pc1", gotpc[1], 32'h4);
      chk("stall_pc2", gotpc[2], 32'h8);
      chk("stall_ins2", gotins[2], mdata(32'h8));
    end

    // Redirect with two requests outstanding.
    do_reset();
    rsp_en = 1'b0;
    cyc();
    cyc();
    cyc();
    #1;
    chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0103;
    cyc();
    #1;
    chk("redir_addr", Addr, 32'h100);
    chk("drain_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rsp_en = 1'b1;
    wait_pops(1, 30);
    if (gotpc.size() >= 1) begin
      chk("redir_pc", gotpc[0], 32'h100);
      chk("redir_ins", gotins[0], mdata(32'h100));
    end

    // Redirect in the same cycle as a handshake.
    do_reset();
    cyc();
    #1;
    chk("same_req_valid", {31'b0, imem_req_valid}, 32'd1);
    redirect_valid  = 1'b1;
    redirect_target = 32'h0000_0200;
    cyc();
    #1;
    chk("same_addr", Addr, 32'h200);
    wait_pops(1, 30);
    if (gotpc.size() >= 1) chk("same_pc", gotpc[0], 32'h200);

    // Address wrap.
    do_reset();
    cyc();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cyc();
    wait_pops(2, 40);
    if (gotpc.size() >= 2) begin
      chk("wrap_pc0", gotpc[0], 32'hFFFF_FFFC);
      chk("wrap_pc1", gotpc[1], 32'h0);
      chk("wrap_ins1", gotins[1], mdata(32'h0));
    end

    // Unexpected response, then asynchronous reset mid-operation.
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_1234;
    cyc();
    #1;
    chk("unexp_err", {31'b0, err_unexpected_rsp}, 32'd1);
    chk("unexp_no_push", {31'b0, if_valid}, 32'd0);
    for (int i = 0; i < 20 && !if_valid; i++) cyc();
    chk("pre_rst_if_valid", {31'b0, if_valid}, 32'd1);
    chk("err_sticky", {31'b0, err_unexpected_rsp}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_addr", Addr, 32'h0);
    chk("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("arst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_if_pc", if_pc, 32'h0);
    chk("arst_if_instr", if_instr, 32'h0);
    chk("arst_err", {31'b0, err_unexpected_rsp}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
